tlk2711_rx_checker: RTL

TLK2711_RX_CHECKER -- requirements
Module: tlk2711_rx_checker

---
 rtl/tlk2711_rx_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tlk2711_rx_checker.sv
// Receive-side checker for a TLK2711 link: idle-based lock, framed incrementing
// payload check (SOF, length, payload, EOF), error classification and counters.
module tlk2711_rx_checker #(
  parameter int MAX_LEN    = 1024,
  parameter int LOCK_IDLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_rxd,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic        i_clr,
  output logic        o_lock,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [2:0]  o_err_code,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  typedef enum logic [2:0] {W_IDLE, W_SOF, W_EOF, W_CERR, W_DATA, W_BADK} word_t;
  typedef enum logic [1:0] {HUNT, LEN, DATA, TAIL} state_t;

  localparam int LW = $clog2(LOCK_IDLES + 1);

  word_t         word;
  state_t        state, state_nx;
  logic [LW-1:0] lock_cnt;
  logic [15:0]   remaining, remaining_nx;
  logic [15:0]   expect_val, expect_nx;
  logic          seeded, seeded_nx;
  logic          ok_ev, err_ev;
  logic [2:0]    code_ev;

  // Any K pattern that is not one of the four known control words is BADK.
  always_comb begin
    word = W_BADK;
    if (!i_rkmsb && !i_rklsb)                       word = W_DATA;
    else if (i_rkmsb && !i_rklsb && i_rxd == 16'hBCC5) word = W_IDLE;
    else if (i_rkmsb && i_rklsb && i_rxd == 16'hFBFB)  word = W_SOF;
    else if (i_rkmsb && i_rklsb && i_rxd == 16'hFDFD)  word = W_EOF;
    else if (i_rkmsb && i_rklsb && i_rxd == 16'hFFFF)  word = W_CERR;
  end

  assign o_lock = (lock_cnt == LW'(LOCK_IDLES));

  always_ff @(posedge clk) begin
    if (rst)                                lock_cnt <= '0;
    else if (word == W_CERR || word == W_BADK) lock_cnt <= '0;
    else if (word == W_IDLE && !o_lock)     lock_cnt <= lock_cnt + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      remaining  <= '0;
      expect_val <= '0;
      seeded     <= 1'b0;
    end else begin
      state      <= state_nx;
      remaining  <= remaining_nx;
      expect_val <= expect_nx;
      seeded     <= seeded_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    expect_nx    = expect_val;
    seeded_nx    = seeded;
    ok_ev        = 1'b0;
    err_ev       = 1'b0;
    code_ev      = 3'd0;
    if (state == HUNT) begin
      if (word == W_SOF && o_lock) state_nx = LEN;
      else if (word == W_CERR || word == W_BADK) begin
        err_ev  = 1'b1;
        code_ev = 3'd6;
      end
    end else begin
      // Inside a frame, control words abort; EOF is only legal in TAIL.
      state_nx = HUNT;
      case (word)
        W_SOF:  begin err_ev = 1'b1; code_ev = 3'd4; end
        W_IDLE: begin err_ev = 1'b1; code_ev = 3'd5; end
        W_EOF: begin
          if (state == TAIL) ok_ev = 1'b1;
          else begin err_ev = 1'b1; code_ev = 3'd5; end
        end
        W_DATA: begin
          case (state)
            LEN: begin
              if (i_rxd != 16'd0 && {16'd0, i_rxd} <= 32'(MAX_LEN)) begin
                remaining_nx = i_rxd;
                seeded_nx    = 1'b0;
                state_nx     = DATA;
              end else begin
                err_ev  = 1'b1;
                code_ev = 3'd1;
              end
            end
            DATA: begin
              if (seeded && i_rxd != expect_val) begin
                err_ev  = 1'b1;
                code_ev = 3'd2;
              end else begin
                expect_nx    = i_rxd + 16'd1;
                seeded_nx    = 1'b1;
                remaining_nx = remaining - 16'd1;
                state_nx     = (remaining == 16'd1) ? TAIL : DATA;
              end
            end
            default: begin err_ev = 1'b1; code_ev = 3'd3; end
          endcase
        end
        default: begin err_ev = 1'b1; code_ev = 3'd6; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= 3'd0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      o_frame_ok  <= ok_ev;
      o_frame_err <= err_ev;
      if (err_ev) o_err_code <= code_ev;
      if (i_clr) begin
        o_frame_cnt <= '0;
        o_err_cnt   <= '0;
      end else begin
        if (ok_ev) o_frame_cnt <= o_frame_cnt + 32'd1;
        if (err_ev && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      end
    end
  end

endmodule
